alsu_cmd_driver: RTL
====================

Name: alsu_cmd_driver

Overview:
Initiator-side companion to the ALSU. It accepts queued operation commands, drives the ALSU input pins for a programmed number of cycles, and captures the registered ALSU result. It detects invalid-operation events by watching ALSU leds[0] toggle, then returns {result, error} through a ready/valid response queue. Bench drivers and firmware-facing wrappers use it as the single-step or chained front end of the ALSU.

Parameters:
CMD_DEPTH, 4, command FIFO entries (power of 2, >=2)
RSP_DEPTH, 4, response FIFO entries (power of 2, >=2); also the in-flight credit limit

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command FIFO not full
cmd_data  in  27  [2:0]A [5:3]B [8:6]opcode [9]cin [10]red_op_A [11]red_op_B [12]bypass_A [13]bypass_B [14]direction [15]chain [18:16]repeat [26:19]serial_bits
rsp_valid  out  1  response FIFO not empty
rsp_ready  in  1  response consumed
rsp_data  out  6  captured ALSU out
rsp_err  out  1  leds[0] changed during the command window
alsu_A, alsu_B, alsu_opcode  out  3 each  to ALSU
alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B, alsu_direction  out  1 each  to ALSU
alsu_out  in  6  from ALSU (registered, 1-cycle latency)
alsu_leds  in  16  from ALSU; only bit 0 used

Behaviour:
- All alsu_* outputs are registered. Idle drive is bypass_A=1 and every other field 0, so ALSU out<=0 with no leds change. Reset loads the idle drive, empties both FIFOs, clears credits, counters and FSM, and sets rsp_valid=0 and cmd_ready=1.
- Reset mid-command aborts it. No response is produced.
- Command FIFO: push on cmd_valid&&cmd_ready. A push to a full FIFO is impossible because cmd_ready=0.
- Credit: outstanding = rsp FIFO count + commands loaded but not yet pushed. A start is allowed only when the cmd FIFO is non-empty and outstanding < RSP_DEPTH.
- FSM IDLE: if a start is allowed, pop the command and load the drive registers at the edge (alsu_serial_in=serial_bits[0], cnt=repeat, idx=0), then go to ISSUE. Otherwise hold the idle drive.
- FSM ISSUE: each cycle is one issue cycle. Total issue cycles = repeat+1.
  - At each edge with cnt>0: cnt--, idx++, alsu_serial_in=serial_bits[idx+1]. All other fields are held.
  - At the edge ending the last issue cycle, set cap_pend. Then:
    - If chain=1 and a start is allowed: load the next command, stay in ISSUE, no bubble.
    - Otherwise: load the idle drive and go to IDLE.
- Capture: the cycle after the last issue cycle has cap_pend=1. At its closing edge, push {alsu_out, err_acc | (alsu_leds[0]!=leds_prev)} and clear cap_pend.
- Error detection:
  - leds_prev samples alsu_leds[0] every cycle.
  - err_acc clears at load.
  - err_acc ORs in (alsu_leds[0]!=leds_prev) in every cycle from the second issue cycle through the last issue cycle.
  - Any toggle counts, so an even number of toggles is still an error.
- Chained command windows never overlap.
- Latency: the command is accepted in cycle T with everything idle. Load happens at edge T+1, issue cycle is T+2 (for repeat=0), capture is T+3, and rsp_valid=1 from T+4.
- Response FIFO pops on rsp_valid&&rsp_ready, and responses are in order. A push and a pop may occur in the same cycle. The credit rule guarantees the FIFO never overflows.
- The ALSU must not be driven by any other source while the driver is out of reset.

Optional Feature:
ALSU_DRV_STATS_EN: adds outputs stat_done[15:0] and stat_err[15:0].
- stat_done increments per response push.
- stat_err increments per push with err=1.
- Both saturate at 16'hFFFF and clear on reset.
Without the macro these ports and their logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset with cmd_valid=0 -> rsp_valid=0, cmd_ready=1, alsu_bypass_A=1, alsu_A=0, alsu_opcode=0.
- Single ADD: A=3, B=5, opcode=2, cin=1, repeat=0, accepted at T -> rsp_valid rises at T+4 with rsp_data=9, rsp_err=0.
- Chained shift then rotate:
  - First command: opcode=4, direction=1, repeat=5, serial_bits=8'b00101101 (bit0 first), chain=1 -> rsp 45 (6'b101101).
  - Second command: opcode=5, direction=0, repeat=0 -> rsp 54 (6'b110110), with no idle cycle between the two commands.
- Invalid opcode=6, bypass both 0, repeat=0 -> rsp_data=0, rsp_err=1. Same with repeat=1 (two toggles) -> rsp_err=1.
- Backpressure: rsp_ready=0, six ADD commands A=i, B=0, cin=0 -> exactly 4 responses held and issue stalls. Then rsp_ready=1 -> rsp_data 0..5 in order with none lost.
- Assert rst during the 3rd issue cycle of a repeat=5 command -> rsp_valid=0, idle drive, no response. A new command after reset completes normally.

Source files
------------

// File: rtl/alsu_cmd_driver.sv
// Queued command front end for the ALSU: drives its pins for repeat+1 cycles, captures the result and flags leds[0] activity.
// Optional build macro ALSU_DRV_STATS_EN adds stat_done/stat_err response counters.
module alsu_cmd_driver #(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [26:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [5:0]  rsp_data,
    output logic        rsp_err,
    output logic [2:0]  alsu_A,
    output logic [2:0]  alsu_B,
    output logic [2:0]  alsu_opcode,
    output logic        alsu_cin,
    output logic        alsu_serial_in,
    output logic        alsu_red_op_A,
    output logic        alsu_red_op_B,
    output logic        alsu_bypass_A,
    output logic        alsu_bypass_B,
    output logic        alsu_direction,
    input  logic [5:0]  alsu_out,
    input  logic [15:0] alsu_leds
`ifdef ALSU_DRV_STATS_EN
   ,output logic [15:0] stat_done,
    output logic [15:0] stat_err
`endif
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RSP_DEPTH);
    localparam int OW  = RAW + 2;

    typedef enum logic {IDLE, ISSUE} state_t;
    state_t state, state_nxt;

    logic [26:0]  cmd_mem [CMD_DEPTH];
    logic [CAW:0] cmd_wp, cmd_rp;
    logic [26:0]  cmd_head;
    logic         cmd_push, cmd_empty;
    logic [6:0]   rsp_mem [RSP_DEPTH];
    logic [RAW:0] rsp_wp, rsp_rp, rsp_count;
    logic         rsp_pop;
    logic [OW-1:0] outstanding;
    logic         start_ok, load, step, last, go_idle;
    logic [7:0]   ser_bits;
    logic         chain_r, cap_pend, cap_err, err_acc, leds_prev, led_tog, acc_en, push_err;
    logic [2:0]   cnt, idx, idx_nxt;
    logic         unused_leds;

    // cmd and rsp are valid/ready ports: a transfer happens on the rising edge where
    // both are high, and valid never waits on ready.
    assign cmd_empty = (cmd_wp == cmd_rp);
    assign cmd_ready = !((cmd_wp[CAW] != cmd_rp[CAW]) && (cmd_wp[CAW-1:0] == cmd_rp[CAW-1:0]));
    assign cmd_push  = cmd_valid && cmd_ready;
    assign cmd_head  = cmd_mem[cmd_rp[CAW-1:0]];

    assign rsp_count = rsp_wp - rsp_rp;
    assign rsp_valid = (rsp_count != '0);
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign {rsp_data, rsp_err} = rsp_mem[rsp_rp[RAW-1:0]];

    // Credits cover the response FIFO plus the command in ISSUE and the one awaiting capture.
    assign outstanding = OW'(rsp_count) + OW'(state == ISSUE) + OW'(cap_pend);
    assign start_ok    = !cmd_empty && (outstanding < OW'(RSP_DEPTH));

    assign idx_nxt  = idx + 3'd1;
    assign led_tog  = (alsu_leds[0] != leds_prev);
    assign acc_en   = (state == ISSUE) && (idx != 3'd0);
    assign push_err = cap_err | led_tog;
    assign unused_leds = ^alsu_leds[15:1];

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        go_idle   = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    load      = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt != 3'd0) begin
                    step = 1'b1;
                end else begin
                    last = 1'b1;
                    if (chain_r && start_ok) begin
                        load = 1'b1;
                    end else begin
                        go_idle   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (cmd_push) cmd_mem[cmd_wp[CAW-1:0]] <= cmd_data;
        if (cap_pend) rsp_mem[rsp_wp[RAW-1:0]] <= {alsu_out, push_err};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_wp <= '0;
            cmd_rp <= '0;
            rsp_wp <= '0;
            rsp_rp <= '0;
        end else begin
            if (cmd_push) cmd_wp <= cmd_wp + (CAW+1)'(1);
            if (load)     cmd_rp <= cmd_rp + (CAW+1)'(1);
            if (cap_pend) rsp_wp <= rsp_wp + (RAW+1)'(1);
            if (rsp_pop)  rsp_rp <= rsp_rp + (RAW+1)'(1);
        end
    end

    // Idle drive is bypass_A with A=0: ALSU output settles to 0 and leds stay quiet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {alsu_A, alsu_B, alsu_opcode} <= '0;
            {alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B} <= '0;
            {alsu_bypass_A, alsu_bypass_B, alsu_direction} <= 3'b100;
            ser_bits <= '0;
            chain_r  <= 1'b0;
            cnt      <= '0;
            idx      <= '0;
        end else if (load) begin
            alsu_A         <= cmd_head[2:0];
            alsu_B         <= cmd_head[5:3];
            alsu_opcode    <= cmd_head[8:6];
            alsu_cin       <= cmd_head[9];
            alsu_red_op_A  <= cmd_head[10];
            alsu_red_op_B  <= cmd_head[11];
            alsu_bypass_A  <= cmd_head[12];
            alsu_bypass_B  <= cmd_head[13];
            alsu_direction <= cmd_head[14];
            chain_r        <= cmd_head[15];
            cnt            <= cmd_head[18:16];
            ser_bits       <= cmd_head[26:19];
            alsu_serial_in <= cmd_head[19];
            idx            <= '0;
        end else if (step) begin
            cnt            <= cnt - 3'd1;
            idx            <= idx_nxt;
            alsu_serial_in <= ser_bits[idx_nxt];
        end else if (go_idle) begin
            {alsu_A, alsu_B, alsu_opcode} <= '0;
            {alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B} <= '0;
            {alsu_bypass_A, alsu_bypass_B, alsu_direction} <= 3'b100;
            chain_r <= 1'b0;
        end
    end

    // cap_err keeps the finished window's error so a chained load can clear err_acc at the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leds_prev <= 1'b0;
            cap_pend  <= 1'b0;
            cap_err   <= 1'b0;
            err_acc   <= 1'b0;
        end else begin
            leds_prev <= alsu_leds[0];
            cap_pend  <= last;
            if (last) cap_err <= err_acc | (acc_en && led_tog);
            if (load)                    err_acc <= 1'b0;
            else if (acc_en && led_tog)  err_acc <= 1'b1;
        end
    end

`ifdef ALSU_DRV_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_done <= '0;
            stat_err  <= '0;
        end else if (cap_pend) begin
            if (stat_done != 16'hFFFF)             stat_done <= stat_done + 16'd1;
            if (push_err && stat_err != 16'hFFFF)  stat_err  <= stat_err + 16'd1;
        end
    end
`endif

endmodule
